// File: rtl/l6_pkg.sv
// Shared defaults for the l6 flip-flop family, so instantiating blocks
// can size and initialise their registers consistently.
package l6_pkg;

    localparam int unsigned L6_WIDTH_DEFAULT = 32'd1;
    localparam logic        L6_RESET_BIT     = 1'b0;

endpackage : l6_pkg

// File: rtl/l6_dff_if.sv
// Bundle of the data/reset signals around an l6_dff; the clock stays a plain port.
interface l6_dff_if #(
    parameter int unsigned WIDTH = 32'd1
);

    logic             reset;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;

    modport master (
        output reset,
        output d,
        input  q,
        input  qn
    );

    modport slave (
        input  reset,
        input  d,
        output q,
        output qn
    );

endinterface : l6_dff_if

// File: rtl/l6_dff.sv
// Leaf D flip-flop with synchronous active-high reset and a complemented output.
// Ports keep the positional order clk, reset, d, q, qn.
module l6_dff
    import l6_pkg::*;
#(
    parameter int unsigned      WIDTH       = L6_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{L6_RESET_BIT}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic [WIDTH-1:0] data_q;

    // Capture register: reset is checked first so it wins over d at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= d;
        end
    end

    assign q  = data_q;
    assign qn = ~data_q;

endmodule : l6_dff

// File: tb/tb_l6_dff.sv
// Directed bench for l6_dff: a default 1-bit instance and an 8-bit instance
// with reset value 8'hA5 share the clock and reset and are checked side by side.
`timescale 1ns/1ps
module tb_l6_dff;

    logic clk;
    int   n_cmp;
    int   n_mis;

    l6_dff_if #(.WIDTH(32'd1)) bus1 ();
    l6_dff_if #(.WIDTH(32'd8)) bus8 ();

    l6_dff dut1 (
        .clk   (clk),
        .reset (bus1.reset),
        .d     (bus1.d),
        .q     (bus1.q),
        .qn    (bus1.qn)
    );

    l6_dff #(.WIDTH(32'd8), .RESET_VALUE(8'hA5)) dut8 (
        .clk   (clk),
        .reset (bus8.reset),
        .d     (bus8.d),
        .q     (bus8.q),
        .qn    (bus8.qn)
    );

    assign bus8.reset = bus1.reset;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %h, expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic q1, input logic [7:0] q8);
        chk({tag, " q1"},  {7'd0, bus1.q},  {7'd0, q1});
        chk({tag, " qn1"}, {7'd0, bus1.qn}, {7'd0, ~q1});
        chk({tag, " q8"},  bus8.q,  q8);
        chk({tag, " qn8"}, bus8.qn, ~q8);
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        bus1.reset = 1'b1;
        bus1.d     = 1'b1;
        bus8.d     = 8'hFF;

        tick();                                   // t=11
        chk_all("reset_capture", 1'b0, 8'hA5);

        bus1.reset = 1'b0;
        bus1.d     = 1'b1;
        bus8.d     = 8'h3C;
        tick();                                   // t=31
        chk_all("data_capture1", 1'b1, 8'h3C);

        #1  bus1.d = 1'b0; bus8.d = 8'h00;        // t=32
        #3  bus1.d = 1'b1; bus8.d = 8'hFF;        // t=35
        #3  chk_all("toggle_hold_a", 1'b1, 8'h3C);// t=38
        #4  bus1.d = 1'b0; bus8.d = 8'h5A;        // t=42
        #3  chk_all("toggle_hold_b", 1'b1, 8'h3C);// t=45
        tick();                                   // t=51
        chk_all("data_capture0", 1'b0, 8'h5A);

        bus1.d = 1'b1;
        bus8.d = 8'h0F;
        tick();                                   // t=71
        chk_all("load_one", 1'b1, 8'h0F);

        bus1.reset = 1'b1;
        bus1.d     = 1'b1;
        bus8.d     = 8'hFF;
        tick();                                   // t=91
        chk_all("reset_priority", 1'b0, 8'hA5);

        bus1.reset = 1'b0;
        bus1.d     = 1'b1;
        bus8.d     = 8'h81;
        tick();                                   // t=111
        chk_all("resume_after_reset", 1'b1, 8'h81);

        #4  bus1.reset = 1'b1;                    // t=115
        #3  chk_all("sync_reset_mid", 1'b1, 8'h81);// t=118
        #4  bus1.reset = 1'b0;                    // t=122
        tick();                                   // t=131
        chk_all("sync_reset_pulse", 1'b1, 8'h81);

        bus1.d = 1'b0;
        bus8.d = 8'h7E;
        @(negedge clk);
        #1;                                       // t=141
        chk_all("negedge_hold", 1'b1, 8'h81);
        tick();                                   // t=151
        chk_all("final_capture", 1'b0, 8'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_l6_dff

// File: doc/l6_dff.md
L6_DFF -- requirements
Module: l6_dff

Interface
REQ-001 Parameter WIDTH, default 1: data width of d, q and qn.
REQ-002 Parameter RESET_VALUE, default all-zeros (WIDTH bits): value loaded into q on reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-005 d  input  WIDTH  data captured on each rising clk edge when reset is low.
REQ-006 q  output  WIDTH  registered data output.
REQ-007 qn  output  WIDTH  bitwise complement of q.
REQ-008 Port order SHALL be clk, reset, d, q, qn, so positional instantiation binds correctly.

Function
REQ-009 On rising clk with reset=1: q SHALL become RESET_VALUE; d is ignored that cycle.
REQ-010 On rising clk with reset=0: q SHALL become the value of d sampled at that edge (latency one edge).
REQ-011 Between rising edges: q SHALL hold; d changes, including glitches or multiple toggles, SHALL have no effect.
REQ-012 qn SHALL equal ~q at all times, combinationally derived from q, never separately registered, so q and qn never disagree.
REQ-013 reset asserted or deasserted between edges SHALL have no effect until the next rising edge (no asynchronous path).
REQ-014 reset and d changing in the same cycle: reset SHALL take priority at the edge.
REQ-015 Reset asserted for one edge in mid-operation: q SHALL take RESET_VALUE at that edge and resume capturing d at the next edge with reset=0.
REQ-016 Falling clk edges SHALL never change q.

Reset
REQ-017 Before the first rising edge with reset=1, q is unknown (X in simulation); no initial value SHALL be relied on.
REQ-018 After one rising edge with reset=1: q=RESET_VALUE and qn=~RESET_VALUE (default q=0, qn=1).
REQ-019 Reset SHALL be the only initialisation mechanism; no initial blocks in synthesizable RTL.

Structure
REQ-020 Single always block on posedge clk, with reset checked first; qn is a continuous assignment.
REQ-021 No sub-modules; the block is a leaf cell.
REQ-022 The default WIDTH and RESET_VALUE constants SHALL live in a shared package (l6_pkg) for reuse by instantiating blocks.
REQ-023 Synthesizable with no latches; one flip-flop per bit of q.

Verification
REQ-024 Bench: clk period 20 time units, clk=0 at t=0, rising edges at t=10, 30, 50, ...
REQ-025 Reset capture: reset=1, d=1 before edge t=10 -> q=0, qn=1 after t=10.
REQ-026 Data capture: reset=0, d=1 before edge t=30 -> q=1, qn=0 after t=30; with d=0 before t=50 -> q=0, qn=1 after t=50.
REQ-027 Mid-cycle toggling: reset=0, d toggled 0->1->0 between t=30 and t=50 with d=0 at t=50 -> q unchanged until t=50, then q=0.
REQ-028 Reset priority: q=1, then reset=1 and d=1 before edge t=70 -> q=0 after t=70; reset=0, d=1 before t=90 -> q=1 after t=90.
REQ-029 Sync check: reset pulsed high between edges, low again before the next edge -> q unchanged.
REQ-030 Invariant on every sample: qn == ~q once reset has been applied; the bench also runs with WIDTH=8 and RESET_VALUE=8'hA5 -> q=8'hA5, qn=8'h5A after reset.
